// File: rtl/tlp2reg_wr.sv
// tlp2reg_wr: decodes single-DW memory-write TLPs from the TRN rx stream into
// a bank of write-only registers. Hits are queued in a small FIFO and handed to
// a slow consumer through a four-phase acc_en/acc_en_ack handshake.
module tlp2reg_wr #(
   parameter int unsigned BARHIT      = 2,
   parameter logic [5:0]  BASE_DW     = 6'h00,
   parameter int unsigned ADDR_W      = 2,
   parameter int unsigned FIFO_AW     = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       trn_rd,
   input  logic [7:0]        trn_rrem_n,
   input  logic              trn_rsof_n,
   input  logic              trn_reof_n,
   input  logic              trn_rsrc_rdy_n,
   input  logic [6:0]        trn_rbar_hit_n,
   output logic [31:0]       acc_data,
   output logic [ADDR_W-1:0] acc_addr,
   output logic              acc_en,
   input  logic              acc_en_ack,
   output logic              fifo_full,
   output logic [15:0]       drop_cnt
);

   localparam int unsigned DEPTH     = 2**FIFO_AW;
   localparam int unsigned PTR_W     = FIFO_AW + 1;
   localparam logic [6:0]  FT_MWR32  = 7'b1000000;
   localparam logic [6:0]  FT_MWR64  = 7'b1100000;
   localparam logic [6:0]  BANK_SIZE = 7'(2**ADDR_W);
   localparam logic [2:0]  BAR_SEL   = 3'(BARHIT);

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [31:0]       data;
   } entry_t;

   typedef enum logic [1:0] {RX_IDLE, RX_H32, RX_H64, RX_D64} rx_state_t;
   typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT_HI, OUT_WAIT_LO} out_state_t;

   function automatic logic [31:0] byteswap(input logic [31:0] b);
      return {b[7:0], b[15:8], b[23:16], b[31:24]};
   endfunction

   rx_state_t         rx_state, rx_next;
   logic [ADDR_W-1:0] rx_idx, rx_idx_nxt;
   out_state_t        out_state, out_next;

   logic              beat_c, sof_c, hdr_hit_c;
   logic [6:0]        diff32_c, diff64_c;
   logic              in32_c, in64_c;
   rx_state_t         hdr_next_c;

   logic              push_c, pop_c, wr_en_c, drop_c, empty_c, full_nxt_c;
   entry_t            push_entry_c, head_c;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_nxt_c, rd_nxt_c;
   entry_t            mem [DEPTH];

   logic [SYNC_STAGES-1:0] ack_sync;
   logic              ack_s_c;
   logic              acc_en_nxt;
   logic [31:0]       data_nxt;
   logic [ADDR_W-1:0] addr_nxt;

   logic              unused_c;
   assign unused_c = ^{trn_rrem_n, trn_rd[55:42], trn_rbar_hit_n};

   // Beat qualification, header decode and DW-offset range checks
   always_comb begin
      beat_c    = !trn_rsrc_rdy_n;
      sof_c     = beat_c && !trn_rsof_n;
      hdr_hit_c = !trn_rbar_hit_n[BAR_SEL] && (trn_rd[41:32] == 10'd1);
      // A borrow wraps the difference above 63, so one compare covers both bounds
      diff32_c  = 7'({1'b0, trn_rd[39:34]}) - 7'({1'b0, BASE_DW});
      diff64_c  = 7'({1'b0, trn_rd[7:2]}) - 7'({1'b0, BASE_DW});
      in32_c    = diff32_c < BANK_SIZE;
      in64_c    = diff64_c < BANK_SIZE;
      hdr_next_c = RX_IDLE;
      if (hdr_hit_c && trn_rd[62:56] == FT_MWR32) begin
         hdr_next_c = RX_H32;
      end else if (hdr_hit_c && trn_rd[62:56] == FT_MWR64) begin
         hdr_next_c = RX_H64;
      end
   end

   // Rx FSM next state and FIFO push request
   always_comb begin
      rx_next           = rx_state;
      rx_idx_nxt        = rx_idx;
      push_c            = 1'b0;
      push_entry_c.idx  = diff32_c[ADDR_W-1:0];
      push_entry_c.data = byteswap(trn_rd[31:0]);
      if (sof_c) begin
         rx_next = hdr_next_c;
      end else if (beat_c) begin
         case (rx_state)
            RX_H32: begin
               push_c  = in32_c;
               rx_next = RX_IDLE;
            end
            RX_H64: begin
               rx_next = RX_IDLE;
               if (trn_reof_n && in64_c) begin
                  rx_next    = RX_D64;
                  rx_idx_nxt = diff64_c[ADDR_W-1:0];
               end
            end
            RX_D64: begin
               push_c            = 1'b1;
               push_entry_c.idx  = rx_idx;
               push_entry_c.data = byteswap(trn_rd[63:32]);
               rx_next           = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
         endcase
      end
   end

   // Rx FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_idx   <= '0;
      end else begin
         rx_state <= rx_next;
         rx_idx   <= rx_idx_nxt;
      end
   end

   // FIFO pointer arithmetic; a push into a full FIFO is dropped even on a pop cycle
   always_comb begin
      wr_en_c    = push_c && !fifo_full;
      drop_c     = push_c && fifo_full;
      empty_c    = (wr_ptr == rd_ptr);
      wr_nxt_c   = wr_ptr + PTR_W'(wr_en_c);
      rd_nxt_c   = rd_ptr + PTR_W'(pop_c);
      full_nxt_c = (PTR_W'(wr_nxt_c - rd_nxt_c) == PTR_W'(DEPTH));
      head_c     = mem[rd_ptr[FIFO_AW-1:0]];
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem[wr_ptr[FIFO_AW-1:0]] <= push_entry_c;
      end
   end

   // FIFO pointers, full flag and saturating drop counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_full <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         wr_ptr    <= wr_nxt_c;
         rd_ptr    <= rd_nxt_c;
         fifo_full <= full_nxt_c;
         if (drop_c && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // Acknowledge synchroniser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], acc_en_ack};
      end
   end
   assign ack_s_c = ack_sync[SYNC_STAGES-1];

   // Output FSM next state: pop, request, wait ack high, wait ack low
   always_comb begin
      out_next   = out_state;
      pop_c      = 1'b0;
      acc_en_nxt = acc_en;
      data_nxt   = acc_data;
      addr_nxt   = acc_addr;
      case (out_state)
         OUT_IDLE: begin
            if (!empty_c) begin
               pop_c    = 1'b1;
               data_nxt = head_c.data;
               addr_nxt = head_c.idx;
               out_next = OUT_REQ;
            end
         end
         OUT_REQ: begin
            acc_en_nxt = 1'b1;
            out_next   = OUT_WAIT_HI;
         end
         OUT_WAIT_HI: begin
            if (ack_s_c) begin
               acc_en_nxt = 1'b0;
               out_next   = OUT_WAIT_LO;
            end
         end
         OUT_WAIT_LO: begin
            if (!ack_s_c) begin
               out_next = OUT_IDLE;
            end
         end
         default: out_next = OUT_IDLE;
      endcase
   end

   // Output FSM state and registered access outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_state <= OUT_IDLE;
         acc_en    <= 1'b0;
         acc_data  <= '0;
         acc_addr  <= '0;
      end else begin
         out_state <= out_next;
         acc_en    <= acc_en_nxt;
         acc_data  <= data_nxt;
         acc_addr  <= addr_nxt;
      end
   end

endmodule

// File: tb/tb_tlp2reg_wr.sv
// tb_tlp2reg_wr: table vectors, hand-written corner sequences and randomized
// rounds checked against a queue-based model of the write bridge.
module tb_tlp2reg_wr;

   localparam int unsigned ADDR_W   = 2;
   localparam int unsigned DEPTH    = 4;
   localparam logic [5:0]  BASE_DW  = 6'h00;
   localparam logic [6:0]  FT_MWR32 = 7'b1000000;
   localparam logic [6:0]  FT_MWR64 = 7'b1100000;
   localparam logic [6:0]  FT_MRD32 = 7'b0000000;

   logic              clk = 1'b0;
   logic              rst;
   logic [63:0]       trn_rd;
   logic [7:0]        trn_rrem_n;
   logic              trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n;
   logic [6:0]        trn_rbar_hit_n;
   logic [31:0]       acc_data;
   logic [ADDR_W-1:0] acc_addr;
   logic              acc_en, acc_en_ack, fifo_full;
   logic [15:0]       drop_cnt;

   int errors = 0;
   int checks = 0;
   int exp_drops = 0;

   tlp2reg_wr #(.BARHIT(2), .BASE_DW(BASE_DW), .ADDR_W(ADDR_W), .FIFO_AW(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n),
      .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
      .trn_rbar_hit_n(trn_rbar_hit_n), .acc_data(acc_data), .acc_addr(acc_addr),
      .acc_en(acc_en), .acc_en_ack(acc_en_ack), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]        ft;
      logic [9:0]        len;
      int                bar;
      logic [5:0]        off;
      logic [31:0]       data;
      int                gaps;
      logic              acc;
      logic [ADDR_W-1:0] exp_addr;
      logic [31:0]       exp_data;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] host_swap(input logic [31:0] d);
      logic [31:0] r;
      r = {<<8{d}};
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] reg_index(input logic [5:0] off);
      int v;
      v = int'(off) - int'(BASE_DW);
      return ADDR_W'(v);
   endfunction

   function automatic logic [63:0] hdr(input logic [6:0] ft, input logic [9:0] len);
      logic [31:0] lo;
      lo = $urandom;
      return {1'b0, ft, 14'h0, len, lo};
   endfunction

   // Idle beats (rdy high, junk elsewhere) then one valid beat
   task automatic beat(input logic [63:0] d, input logic sof, input logic eof, input int bar, input int gaps);
      for (int i = 0; i < gaps; i++) begin
         @(negedge clk);
         trn_rsrc_rdy_n = 1'b1;
         trn_rd         = {$urandom, $urandom};
         trn_rsof_n     = 1'($urandom_range(0, 1));
         trn_reof_n     = 1'($urandom_range(0, 1));
         trn_rbar_hit_n = 7'($urandom);
      end
      @(negedge clk);
      trn_rsrc_rdy_n = 1'b0;
      trn_rd         = d;
      trn_rsof_n     = ~sof;
      trn_reof_n     = ~eof;
      trn_rbar_hit_n = ~(7'd1 << bar);
   endtask

   task automatic idle_bus();
      @(negedge clk);
      trn_rsrc_rdy_n = 1'b1;
      trn_rsof_n     = 1'b1;
      trn_reof_n     = 1'b1;
      trn_rbar_hit_n = 7'h7F;
   endtask

   task automatic send_tlp(input logic [6:0] ft, input logic [9:0] len, input int bar,
                           input logic [5:0] off, input logic [31:0] data, input int glo, input int ghi);
      if (ft == FT_MWR64) begin
         beat(hdr(ft, len), 1'b1, 1'b0, bar, 0);
         beat({32'h0, 24'h0, off, 2'b00}, 1'b0, 1'b0, bar, $urandom_range(glo, ghi));
         beat({data, 32'($urandom)}, 1'b0, 1'b1, bar, $urandom_range(glo, ghi));
      end else begin
         beat(hdr(ft, len), 1'b1, 1'b0, bar, 0);
         beat({24'h0, off, 2'b00, data}, 1'b0, 1'b1, bar, $urandom_range(glo, ghi));
      end
   endtask

   // Consumer: wait for a request, capture it, complete the four-phase handshake
   task automatic take(output logic ok, output logic [ADDR_W-1:0] a, output logic [31:0] d);
      int n;
      ok = 1'b0; a = '0; d = '0; n = 0;
      while (acc_en !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      if (acc_en === 1'b1) begin
         a = acc_addr;
         d = acc_data;
         acc_en_ack = 1'b1;
         n = 0;
         while (acc_en !== 1'b0 && n < 50) begin @(negedge clk); n++; end
         ok = (acc_en === 1'b0);
         acc_en_ack = 1'b0;
      end
   endtask

   task automatic expect_write(input string tag, input logic [ADDR_W-1:0] ea, input logic [31:0] ed);
      logic ok;
      logic [ADDR_W-1:0] a;
      logic [31:0] d;
      take(ok, a, d);
      check({tag, "_handshake"}, 64'(ok), 64'd1);
      check({tag, "_addr"}, 64'(a), 64'(ea));
      check({tag, "_data"}, 64'(d), 64'(ed));
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (acc_en !== 1'b0) seen = 1'b1;
      end
      check({tag, "_no_request"}, 64'(seen), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ADDR_W-1:0] eq_a[$];
      logic [31:0]       eq_d[$];
      int                n_tlp, held, kind, bar, b, glo;
      logic [6:0]        ft;
      logic [9:0]        len;
      logic [5:0]        off;
      logic [31:0]       d;
      logic [ADDR_W-1:0] ea;
      logic [31:0]       ed;

      rst = 1'b1; acc_en_ack = 1'b0; trn_rd = '0; trn_rrem_n = '0;
      trn_rsof_n = 1'b1; trn_reof_n = 1'b1; trn_rsrc_rdy_n = 1'b1; trn_rbar_hit_n = 7'h7F;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_acc_en", 64'(acc_en), 64'd0);
      check("rst_acc_data", 64'(acc_data), 64'd0);
      check("rst_acc_addr", 64'(acc_addr), 64'd0);
      check("rst_fifo_full", 64'(fifo_full), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      rst = 1'b0;
      expect_quiet("post_reset", 10);

      // Table vectors
      vecs[0] = '{FT_MWR32, 10'd1, 2, 6'd1, 32'h11223344, 0, 1'b1, 2'd1, 32'h44332211};
      vecs[1] = '{FT_MWR64, 10'd1, 2, 6'd3, 32'hDEADBEEF, 1, 1'b1, 2'd3, 32'hEFBEADDE};
      vecs[2] = '{FT_MWR32, 10'd1, 0, 6'd4, 32'h12345678, 0, 1'b0, 2'd0, 32'h0};
      vecs[3] = '{FT_MWR32, 10'd2, 2, 6'd1, 32'h12345678, 0, 1'b0, 2'd0, 32'h0};
      vecs[4] = '{FT_MRD32, 10'd1, 2, 6'd1, 32'h12345678, 0, 1'b0, 2'd0, 32'h0};
      vecs[5] = '{FT_MWR64, 10'd1, 2, 6'd2, 32'h01020304, 2, 1'b1, 2'd2, 32'h04030201};
      vecs[6] = '{FT_MWR32, 10'd1, 2, 6'd0, 32'hA5B6C7D8, 1, 1'b1, 2'd0, 32'hD8C7B6A5};
      vecs[7] = '{FT_MWR64, 10'd1, 2, 6'd9, 32'h0BADF00D, 0, 1'b0, 2'd0, 32'h0};
      foreach (vecs[i]) begin
         send_tlp(vecs[i].ft, vecs[i].len, vecs[i].bar, vecs[i].off, vecs[i].data, vecs[i].gaps, vecs[i].gaps);
         idle_bus();
         if (vecs[i].acc) expect_write($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_data);
         else expect_quiet($sformatf("vec%0d", i), 20);
      end

      // Request and acknowledge latency
      expect_quiet("pre_timing", 5);
      send_tlp(FT_MWR32, 10'd1, 2, 6'd1, 32'h11223344, 0, 0);
      idle_bus();
      check("lat_en_after_E", 64'(acc_en), 64'd0);
      @(negedge clk);
      check("lat_en_after_E1", 64'(acc_en), 64'd0);
      check("lat_data_after_E1", 64'(acc_data), 64'h44332211);
      check("lat_addr_after_E1", 64'(acc_addr), 64'd1);
      @(negedge clk);
      check("lat_en_after_E2", 64'(acc_en), 64'd1);
      acc_en_ack = 1'b1;
      repeat (2) @(negedge clk);
      check("ack_en_after_2_edges", 64'(acc_en), 64'd1);
      @(negedge clk);
      check("ack_en_after_3_edges", 64'(acc_en), 64'd0);
      send_tlp(FT_MWR32, 10'd1, 2, 6'd2, 32'hCAFEF00D, 0, 0);
      idle_bus();
      repeat (8) @(negedge clk);
      check("ack_held_high_no_req", 64'(acc_en), 64'd0);
      acc_en_ack = 1'b0;
      repeat (4) @(negedge clk);
      check("relaunch_en_after_4", 64'(acc_en), 64'd0);
      check("relaunch_data_after_4", 64'(acc_data), 64'h0DF0FECA);
      @(negedge clk);
      check("relaunch_en_after_5", 64'(acc_en), 64'd1);
      expect_write("relaunch", 2'd2, 32'h0DF0FECA);
      expect_quiet("post_timing", 10);

      // Overflow with a stalled consumer
      for (int i = 0; i < 6; i++)
         send_tlp(FT_MWR32, 10'd1, 2, 6'(i % 4), 32'h10000000 + 32'(i * 32'h111), 0, 0);
      idle_bus();
      repeat (3) @(negedge clk);
      exp_drops = 1;
      check("ovf_acc_en", 64'(acc_en), 64'd1);
      check("ovf_fifo_full", 64'(fifo_full), 64'd1);
      check("ovf_drop_cnt", 64'(drop_cnt), 64'(exp_drops));
      for (int i = 0; i < 5; i++)
         expect_write($sformatf("ovf%0d", i), ADDR_W'(i % 4), host_swap(32'h10000000 + 32'(i * 32'h111)));
      expect_quiet("ovf_drained", 15);
      check("ovf_full_cleared", 64'(fifo_full), 64'd0);

      // New SOF while in H64, and while in D64
      beat(hdr(FT_MWR64, 10'd1), 1'b1, 1'b0, 2, 0);
      send_tlp(FT_MWR32, 10'd1, 2, 6'd2, 32'h55667788, 0, 0);
      idle_bus();
      expect_write("abort_h64", 2'd2, 32'h88776655);
      expect_quiet("abort_h64", 15);
      beat(hdr(FT_MWR64, 10'd1), 1'b1, 1'b0, 2, 0);
      beat({32'h0, 32'h0000000C}, 1'b0, 1'b0, 2, 0);
      send_tlp(FT_MWR32, 10'd1, 2, 6'd0, 32'h99AABBCC, 0, 0);
      idle_bus();
      expect_write("abort_d64", 2'd0, 32'hCCBBAA99);
      expect_quiet("abort_d64", 15);

      // Truncated MWr64: EOF on the address beat, trailing beat must be ignored
      beat(hdr(FT_MWR64, 10'd1), 1'b1, 1'b0, 2, 0);
      beat({32'h0, 32'h00000004}, 1'b0, 1'b1, 2, 0);
      beat({32'h13579BDF, 32'h0}, 1'b0, 1'b1, 2, 0);
      idle_bus();
      expect_quiet("truncated", 20);

      // Reset while a request is outstanding and two entries are queued
      for (int i = 0; i < 3; i++)
         send_tlp(FT_MWR32, 10'd1, 2, 6'(i), 32'hC0DE0000 + 32'(i), 0, 0);
      idle_bus();
      repeat (3) @(negedge clk);
      check("prerst_acc_en", 64'(acc_en), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_acc_en_async", 64'(acc_en), 64'd0);
      check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
      check("midrst_fifo_full", 64'(fifo_full), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_drops = 0;
      beat({24'h0, 6'd1, 2'b00, 32'h77777777}, 1'b0, 1'b1, 2, 0);
      idle_bus();
      expect_quiet("after_rst", 20);
      send_tlp(FT_MWR32, 10'd1, 2, 6'd3, 32'h0F1E2D3C, 0, 0);
      idle_bus();
      expect_write("after_rst_new", 2'd3, 32'h3C2D1E0F);
      check("after_rst_drop_cnt", 64'(drop_cnt), 64'd0);

      // Randomized rounds: stalled consumer, then drain and compare with the model
      for (int r = 0; r < 8; r++) begin
         eq_a.delete();
         eq_d.delete();
         held  = 0;
         n_tlp = $urandom_range(1, 8);
         acc_en_ack = 1'b0;
         for (int t = 0; t < n_tlp; t++) begin
            kind = $urandom_range(0, 5);
            ft   = ($urandom_range(0, 1) != 0) ? FT_MWR64 : FT_MWR32;
            len  = 10'd1;
            bar  = 2;
            off  = 6'($urandom_range(0, 3));
            d    = $urandom;
            case (kind)
               2: off = 6'($urandom_range(4, 63));
               3: begin b = $urandom_range(0, 5); if (b >= 2) b++; bar = b; end
               4: len = 10'($urandom_range(2, 1023));
               5: ft = FT_MRD32;
               default: ;
            endcase
            glo = 0;
            send_tlp(ft, len, bar, off, d, glo, 2);
            if (kind <= 1) begin
               if (held < 1 + int'(DEPTH)) begin
                  eq_a.push_back(reg_index(off));
                  eq_d.push_back(host_swap(d));
                  held++;
               end else begin
                  exp_drops++;
               end
            end
         end
         idle_bus();
         repeat (4) @(negedge clk);
         check($sformatf("rnd%0d_drop_cnt", r), 64'(drop_cnt), 64'(exp_drops));
         check($sformatf("rnd%0d_fifo_full", r), 64'(fifo_full), 64'(held == 1 + int'(DEPTH)));
         check($sformatf("rnd%0d_acc_en", r), 64'(acc_en), 64'(held > 0));
         while (eq_a.size() > 0) begin
            ea = eq_a.pop_front();
            ed = eq_d.pop_front();
            expect_write($sformatf("rnd%0d", r), ea, ed);
         end
         expect_quiet($sformatf("rnd%0d_end", r), 12);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
